// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_arb_pkg;

    localparam int unsigned DEPTH_DEFAULT        = 2;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned ADDR_W               = 5;
    localparam int unsigned DATA_W               = 32;

    // One queued MDU write; valid drops when a newer WB write hits the same register.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_entry_t;

    // Owner of the register-file write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_HEAD
    } grant_e;

    function automatic logic [31:0] addr_onehot(input logic [ADDR_W-1:0] a);
        return 32'(1) << a;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request/response bundle between the pipeline/MDU side and the write arbiter.
interface rf_write_arbiter_if;
    import rf_arb_pkg::*;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [31:0]       busy_mask;
    logic              stall_req;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        input  rf_write, rf_waddr, rf_wdata,
        input  busy_mask, stall_req
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        output rf_write, rf_waddr, rf_wdata,
        output busy_mask, stall_req
    );

endinterface

// File: rtl/rf_arb_queue.sv
// FIFO of pending MDU writes with invalidate-by-address and a registered busy mask.
module rf_arb_queue
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_i,
    input  logic [ADDR_W-1:0] enq_addr_i,
    input  logic [DATA_W-1:0] enq_data_i,
    input  logic              pop_i,
    input  logic              inv_i,
    input  logic [ADDR_W-1:0] inv_addr_i,
    output rf_entry_t         head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [31:0]       busy_mask_o
);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    rf_entry_t     entries_q [DEPTH];
    rf_entry_t     entries_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_o      = entries_q[rd_ptr_q];
    assign busy_mask_o = busy_q;

    // Next entry contents: invalidate matches, retire the head, then write the new tail.
    // The busy mask is derived from the next-state entries so it stays in step with them.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_d[PW'(i)] = entries_q[PW'(i)];
            if (inv_i && (entries_q[PW'(i)].addr == inv_addr_i)) begin
                entries_d[PW'(i)].valid = 1'b0;
            end
        end
        if (pop_i) begin
            entries_d[rd_ptr_q].valid = 1'b0;
        end
        if (enq_i) begin
            entries_d[wr_ptr_q] = '{valid: 1'b1, addr: enq_addr_i, data: enq_data_i};
        end
        busy_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_d[PW'(i)].valid) begin
                busy_d = busy_d | addr_onehot(entries_d[PW'(i)].addr);
            end
        end
    end

    // Pointer and occupancy update; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        rd_ptr_d = pop_i ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = enq_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        unique case ({enq_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state register; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PW'(i)] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PW'(i)] <= entries_d[PW'(i)];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and queued MDU results.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    grant_e        gnt;
    rf_entry_t     head;
    logic          full;
    logic          empty;
    logic          wb_hit;
    logic          pop;
    logic          enq;
    logic [SW-1:0] starve_q, starve_d;

    assign wb_hit        = bus.wb_valid && (bus.wb_addr != '0);
    assign pop           = (gnt == GNT_HEAD);
    assign bus.mdu_ready = !full;
    // Address-0 handshakes are accepted but never stored.
    assign enq           = bus.mdu_valid && !full && (bus.mdu_addr != '0);
    assign bus.stall_req = (starve_q == SW'(STARVE_LIMIT));

    rf_arb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .enq_i       (enq),
        .enq_addr_i  (bus.mdu_addr),
        .enq_data_i  (bus.mdu_data),
        .pop_i       (pop),
        .inv_i       (gnt == GNT_WB),
        .inv_addr_i  (bus.wb_addr),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .busy_mask_o (bus.busy_mask)
    );

    // Port grant: writeback first, then the queue head; nothing while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (wb_hit) begin
                gnt = GNT_WB;
            end else if (!empty) begin
                gnt = GNT_HEAD;
            end
        end
    end

    // Write-port mux; an invalidated head is retired silently with the port idle.
    always_comb begin
        bus.rf_write = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        unique case (gnt)
            GNT_WB: begin
                bus.rf_write = 1'b1;
                bus.rf_waddr = bus.wb_addr;
                bus.rf_wdata = bus.wb_data;
            end
            GNT_HEAD: begin
                if (head.valid) begin
                    bus.rf_write = 1'b1;
                    bus.rf_waddr = head.addr;
                    bus.rf_wdata = head.data;
                end
            end
            default: begin
            end
        endcase
    end

    // Starve counter next state: counts cycles a waiting head is passed over, saturating.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: number of queued multi-cycle-unit (MDU) write entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: cycles the queue head may wait before the block stalls the pipeline.
REQ-003 The block SHALL have input clk, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have inputs wb_valid (1), wb_addr (5) and wb_data (32): the pipeline writeback request.
REQ-006 The block SHALL have inputs mdu_valid (1), mdu_addr (5) and mdu_data (32): the MDU result request.
REQ-007 The block SHALL have output mdu_ready, 1 bit: the queue accepts an MDU entry this cycle.
REQ-008 The block SHALL have outputs rf_write (1), rf_waddr (5) and rf_wdata (32), driving the register file write port (write, w_addr, data_in).
REQ-009 The block SHALL have output busy_mask, 32 bits: bit n is set while a queued entry targets register n.
REQ-010 The block SHALL have output stall_req, 1 bit: the pipeline must hold wb_valid low next cycle.

Function
REQ-011 An MDU handshake SHALL occur on a rising edge with mdu_valid and mdu_ready both high; mdu_ready SHALL equal !full, from registered state only.
REQ-012 A handshake with mdu_addr != 0 SHALL enqueue {addr, data}; with mdu_addr == 0 it SHALL complete without enqueuing.
REQ-013 The write-port grant SHALL be combinational: a WB grant when wb_valid and wb_addr != 0; otherwise a head grant when the queue is non-empty; otherwise no write.
REQ-014 On a WB grant the outputs SHALL be rf_write=1, rf_waddr=wb_addr, rf_wdata=wb_data; on a head grant they SHALL carry the head entry; with no grant, rf_write=0 and rf_waddr/rf_wdata=0.
REQ-015 A head grant SHALL pop the head at the same rising edge, so an entry enqueued at edge k is written no earlier than the cycle after edge k.
REQ-016 A simultaneous pop and enqueue SHALL be legal, and the occupancy count SHALL stay unchanged.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH; full = (count == DEPTH) and empty = (count == 0).
REQ-018 On a WB grant to address A, every queued entry with addr == A SHALL be invalidated (the newer write wins).
REQ-019 An invalidated entry reaching the head SHALL be popped with rf_write=0 in that cycle and SHALL be counted as a pop.
REQ-020 busy_mask SHALL be the OR of the one-hot addresses of valid queued entries, and it SHALL be registered consistently with the queue state.
REQ-021 The starve counter SHALL increment each cycle the queue is non-empty and the head is not granted; it SHALL clear on a head pop or when the queue is empty, and SHALL saturate at STARVE_LIMIT.
REQ-022 stall_req SHALL be high while starve count == STARVE_LIMIT.
REQ-023 If wb_valid is nonetheless high during stall_req, WB SHALL keep priority and the counter SHALL remain saturated.

Reset
REQ-024 While rst is high: count=0, both pointers=0, all entries invalid, starve count=0.
REQ-025 While rst is high, outputs SHALL be rf_write=0, rf_waddr=0, rf_wdata=0, busy_mask=0, stall_req=0, mdu_ready=1.
REQ-026 Reset mid-operation SHALL discard all queued entries without writing them.
REQ-027 Deassertion of reset SHALL take effect at the next rising edge.

Structure
REQ-028 A shared package rf_arb_pkg SHALL hold the default constants for DEPTH and STARVE_LIMIT and the queue entry typedef {valid, addr[4:0], data[31:0]}.
REQ-029 The block SHALL contain one sub-module, rf_arb_queue, holding the entry storage, pointers, count, per-entry invalidate-by-address and busy_mask generation.
REQ-030 Grant muxing and the starve counter SHALL live in rf_write_arbiter.

Verification
REQ-031 Scenario: MDU enqueues addr 5, data 0x1234 with no WB -> next cycle rf_write=1, rf_waddr=5, rf_wdata=0x1234; busy_mask bit 5 set for exactly that one cycle.
REQ-032 Scenario: WB addr 3, data 0xAA in the same cycle as queued head addr 7 -> WB written first; addr 7 written in the next WB-idle cycle.
REQ-033 Scenario: queue holds addr 9, then WB writes addr 9, data 0x55 -> entry invalidated, busy_mask bit 9 clears, and a later pop drives rf_write=0.
REQ-034 Scenario: two enqueues with DEPTH=2 and WB busy -> mdu_ready=0; after 4 ungranted cycles stall_req=1; it drops after the head pop.
REQ-035 Scenario: mdu_addr=0, or wb_addr=0 with wb_valid=1 -> handshake completes and rf_write stays 0.
REQ-036 Scenario: rst asserted with 2 entries queued -> busy_mask=0 and mdu_ready=1 immediately, and neither entry is ever written.
